// File: rtl/sort_stream_out.sv
// sort_stream_out: captures a sorted array and streams it one element per ready handshake, flagging order violations
module sort_stream_out #(
   parameter int SIZE_DATA  = 8,
   parameter int NUMBER_ARR = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_load,
   input  logic [SIZE_DATA*NUMBER_ARR-1:0]   i_data,
   input  logic                              i_ready,
   output logic                              o_busy,
   output logic                              o_valid,
   output logic [SIZE_DATA-1:0]              o_data,
   output logic [$clog2(NUMBER_ARR)-1:0]     o_index,
   output logic                              o_last,
   output logic                              o_order_err,
   output logic                              o_done
);
   localparam int IW = $clog2(NUMBER_ARR);
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
   state_t               r_state;
   logic [SIZE_DATA-1:0] r_buf [NUMBER_ARR];
   logic [IW-1:0]        r_idx;
   logic [SIZE_DATA-1:0] r_prev;
   logic                 r_err;
   logic                 w_valid;
   logic                 w_last;
   logic                 w_xfer;
   logic [SIZE_DATA-1:0] w_elem;
   assign w_valid = r_state == S_STREAM;
   assign w_last  = r_idx == IW'(NUMBER_ARR - 1);
   assign w_xfer  = w_valid & i_ready;
   assign w_elem  = r_buf[r_idx];
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_prev  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_load) begin
               for (int k = 0; k < NUMBER_ARR; k++) r_buf[k] <= i_data[k*SIZE_DATA +: SIZE_DATA];
               r_idx   <= '0;
               r_err   <= 1'b0;
               r_state <= S_STREAM;
            end
            S_STREAM: if (w_xfer) begin
               r_prev <= w_elem;
               if (r_idx != '0 && w_elem < r_prev) r_err <= 1'b1;
               // index parks at 0 after the last element so it never runs past NUMBER_ARR-1
               r_idx   <= w_last ? '0 : r_idx + IW'(1);
               r_state <= w_last ? S_DONE : S_STREAM;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_busy      = r_state != S_IDLE;
   assign o_valid     = w_valid;
   assign o_data      = w_valid ? w_elem : '0;
   assign o_index     = r_idx;
   assign o_last      = w_valid & w_last;
   assign o_order_err = r_err;
   assign o_done      = r_state == S_DONE;
endmodule

// File: tb/tb_sort_stream_out.sv
// tb_sort_stream_out: randomized scenarios checked against an array-level model of the stream
module tb_sort_stream_out;
   localparam int N  = 8;
   localparam int W  = 8;
   localparam int IW = 3;
   typedef logic [W-1:0] arr_t [N];
   logic           i_clk = 1'b0;
   logic           i_rst;
   logic           i_load;
   logic           i_ready;
   logic [W*N-1:0] i_data;
   logic           o_busy, o_valid, o_last, o_order_err, o_done;
   logic [W-1:0]   o_data;
   logic [IW-1:0]  o_index;
   int n_chk = 0;
   int n_pass = 0;
   always #5 i_clk = ~i_clk;
   sort_stream_out #(.SIZE_DATA(W), .NUMBER_ARR(N)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_data(i_data), .i_ready(i_ready),
      .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data), .o_index(o_index),
      .o_last(o_last), .o_order_err(o_order_err), .o_done(o_done)
   );
   function automatic logic [W*N-1:0] pack(input arr_t a);
      logic [W*N-1:0] p;
      for (int k = 0; k < N; k++) p[k*W +: W] = a[k];
      return p;
   endfunction
   // true when any element among the first k is smaller than its predecessor
   function automatic logic drop_before(input arr_t a, input int k);
      for (int m = 1; m < k; m++) if (a[m] < a[m-1]) return 1'b1;
      return 1'b0;
   endfunction
   function automatic logic [15:0] obs_all();
      return {o_busy, o_valid, o_last, o_done, o_order_err, o_index, o_data};
   endfunction
   function automatic logic [15:0] obs_noidx();
      return {o_busy, o_valid, o_last, o_done, o_order_err, IW'(0), o_data};
   endfunction
   // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready
   task automatic run_stream(input string name, input arr_t a, input int mode, input int abort_at, input bit reload);
      int k = 0;
      int c = 0;
      logic [15:0] exp;
      arr_t rev;
      for (int i = 0; i < N; i++) rev[i] = W'(N - i);
      n_chk++;
      if (o_valid !== 1'b0) $display("FAIL %s pre_load valid got=%b exp=0", name, o_valid); else n_pass++;
      i_data  = pack(a);
      i_load  = 1'b1;
      i_ready = 1'($urandom % 2);
      @(negedge i_clk);
      i_load = 1'b0;
      while (k < N && c < 200) begin
         exp = {1'b1, 1'b1, 1'(k == N-1), 1'b0, drop_before(a, k), IW'(k), a[k]};
         n_chk++;
         if (obs_all() !== exp) $display("FAIL %s stream k=%0d got=%h exp=%h", name, k, obs_all(), exp); else n_pass++;
         if (k == abort_at) begin
            i_rst = 1'b1; i_load = 1'b1; i_ready = 1'b1;
            @(negedge i_clk);
            i_rst = 1'b0; i_load = 1'b0;
            n_chk++;
            if (obs_all() !== 16'h0) $display("FAIL %s abort got=%h exp=0000", name, obs_all()); else n_pass++;
            @(negedge i_clk);
            n_chk++;
            if (obs_all() !== 16'h0) $display("FAIL %s abort_no_done got=%h exp=0000", name, obs_all()); else n_pass++;
            return;
         end
         i_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(c % 3 == 0) : 1'($urandom % 2);
         i_data  = (reload && c == 2) ? pack(rev) : i_data;
         i_load  = reload && c == 2;
         if (i_ready) k++;
         c++;
         @(negedge i_clk);
      end
      n_chk++;
      if (c >= 200) $display("FAIL %s timeout transfers got=%0d exp=%0d", name, k, N); else n_pass++;
      exp = {1'b1, 1'b0, 1'b0, 1'b1, drop_before(a, N), IW'(0), W'(0)};
      n_chk++;
      if (obs_noidx() !== exp) $display("FAIL %s done got=%h exp=%h", name, obs_noidx(), exp); else n_pass++;
      if (reload) begin i_data = pack(rev); i_load = 1'b1; end
      i_ready = 1'($urandom % 2);
      @(negedge i_clk);
      i_load = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 1'b0, drop_before(a, N), IW'(0), W'(0)};
      n_chk++;
      if (obs_noidx() !== exp) $display("FAIL %s idle_after got=%h exp=%h", name, obs_noidx(), exp); else n_pass++;
   endtask
   function automatic arr_t rand_sorted();
      arr_t a;
      a[0] = W'($urandom % 32);
      for (int i = 1; i < N; i++) a[i] = a[i-1] + W'($urandom % 28);
      return a;
   endfunction
   function automatic arr_t rand_any();
      arr_t a;
      for (int i = 0; i < N; i++) a[i] = W'($urandom);
      return a;
   endfunction
   function automatic arr_t seq_arr();
      arr_t a;
      for (int i = 0; i < N; i++) a[i] = W'(i + 1);
      return a;
   endfunction
   task automatic test_reset();
      i_rst = 1'b1; i_load = 1'b1; i_ready = 1'b1; i_data = pack(seq_arr());
      repeat (2) @(negedge i_clk);
      n_chk++;
      if (obs_all() !== 16'h0) $display("FAIL reset outputs got=%h exp=0000", obs_all()); else n_pass++;
      i_rst = 1'b0; i_load = 1'b0;
      @(negedge i_clk);
      n_chk++;
      if (obs_all() !== 16'h0) $display("FAIL reset idle got=%h exp=0000", obs_all()); else n_pass++;
   endtask
   task automatic test_basic();
      run_stream("basic", seq_arr(), 0, -1, 1'b0);
   endtask
   task automatic test_backpressure();
      run_stream("backpressure", seq_arr(), 1, -1, 1'b0);
   endtask
   task automatic test_order_err();
      arr_t a;
      a = '{8'd3, 8'd5, 8'd5, 8'd2, 8'd9, 8'd9, 8'd9, 8'd9};
      run_stream("order_err", a, 0, -1, 1'b0);
      n_chk++;
      if (o_order_err !== 1'b1) $display("FAIL order_err sticky got=%b exp=1", o_order_err); else n_pass++;
      run_stream("order_clear", seq_arr(), 2, -1, 1'b0);
   endtask
   task automatic test_load_ignored();
      run_stream("load_ignored", seq_arr(), 1, -1, 1'b1);
   endtask
   task automatic test_reset_abort();
      run_stream("abort", seq_arr(), 0, 3, 1'b0);
      run_stream("after_abort", seq_arr(), 0, -1, 1'b0);
   endtask
   task automatic test_back_to_back();
      run_stream("b2b_a", rand_sorted(), 0, -1, 1'b0);
      run_stream("b2b_b", rand_any(), 0, -1, 1'b0);
   endtask
   task automatic test_random();
      for (int t = 0; t < 6; t++)
         run_stream("random", (t % 2) ? rand_any() : rand_sorted(), int'($urandom % 3), -1, 1'($urandom % 2));
   endtask
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_order_err();
      test_load_ignored();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sort_stream_out.md
SORT_STREAM_OUT -- requirements
Module: sort_stream_out

Interface
REQ-001 Parameter SIZE_DATA, default 8, bit width of one array element.
REQ-002 Parameter NUMBER_ARR, default 8, number of elements per array; legal range 2..256.
REQ-003 Timing: one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_load  input  1  one-cycle capture strobe, driven by the sorter's done output.
REQ-007 i_data  input  SIZE_DATA x NUMBER_ARR  sorted array from the sorter; index 0 is the smallest element.
REQ-008 o_busy  output  1  high whenever state is not IDLE.
REQ-009 o_valid  output  1  an element is presented on o_data.
REQ-010 i_ready  input  1  downstream accepts the element this cycle.
REQ-011 o_data  output  SIZE_DATA  current element; zero when o_valid is low.
REQ-012 o_index  output  $clog2(NUMBER_ARR)  array index of the presented element.
REQ-013 o_last  output  1  high with o_valid when o_index equals NUMBER_ARR-1.
REQ-014 o_order_err  output  1  sticky flag: a streamed element was smaller than its predecessor.
REQ-015 o_done  output  1  one-cycle pulse after the final element transfers.

Function
REQ-016 The state machine SHALL have three states: IDLE, STREAM and DONE.
REQ-017 IDLE with i_load=1: capture all of i_data into an internal buffer, set the index to 0, clear o_order_err, and go to STREAM on the next edge.
REQ-018 i_load SHALL be ignored in STREAM and DONE; the buffer SHALL NOT change outside IDLE capture.
REQ-019 Latency: i_load sampled at edge N gives o_valid=1 with o_index=0 after edge N+1 and before edge N+2.
REQ-020 o_valid=1 exactly while in STREAM; o_data=buffer[o_index].
REQ-021 Transfer: o_valid and i_ready both high at an edge.
- On a transfer the index increments by 1.
- With no transfer, o_data, o_index and o_valid SHALL hold stable.
REQ-022 A transfer with o_last=1 SHALL move STREAM to DONE; o_valid falls on the same edge.
REQ-023 DONE SHALL last exactly one cycle, with o_done=1 and o_valid=0, then return to IDLE.
REQ-024 Throughput: with i_ready held high, NUMBER_ARR transfers SHALL occur on consecutive cycles.
REQ-025 Full cycle count, load to done: NUMBER_ARR+2 cycles at i_ready=1.
REQ-026 Order check on each transfer with index>0:
- Compare the unsigned element against the previous transferred element, held in a SIZE_DATA register.
- If it is strictly less, set o_order_err.
- Equal values are legal.
REQ-027 o_order_err SHALL remain set until the next accepted i_load or reset.
REQ-028 i_load in the same cycle as the DONE state SHALL be ignored; a new capture is possible from the following IDLE cycle.
REQ-029 i_ready while o_valid=0 SHALL have no effect.
REQ-030 The index SHALL never exceed NUMBER_ARR-1 (no wrap-around past the last element).

Reset
REQ-031 i_rst=1 at an edge SHALL force state IDLE, index 0, and the previous-element register to 0.
REQ-032 Output values under reset: o_busy=0, o_valid=0, o_data=0, o_index=0, o_last=0, o_order_err=0, o_done=0.
REQ-033 Reset SHALL take priority over i_load and over any transfer in the same cycle.
REQ-034 Reset mid-STREAM SHALL abort the stream with no o_done pulse; buffer contents are don't-care.

Verification
REQ-035 Basic stream: i_data={1,2,3,4,5,6,7,8}, i_load pulse, i_ready=1.
- o_valid is high for 8 consecutive cycles with o_data 1..8.
- o_last is high with 8.
- o_done pulses once, the cycle after; o_order_err=0.
REQ-036 Backpressure: same data, i_ready toggled 1,0,0,1,...
- o_data/o_index are stable during stalls.
- Exactly 8 transfers, in order.
- o_done follows the last transfer only.
REQ-037 Order error: i_data={3,5,5,2,9,9,9,9}.
- o_order_err rises at the edge transferring element 2 (index 3) and stays high through DONE.
- The next load with sorted data clears it.
REQ-038 Load ignored: a second i_load with {8,7,...,1} during STREAM leaves the original stream unchanged.
REQ-039 Reset abort: i_rst asserted after the 3rd transfer.
- All outputs are 0 on the next cycle; no o_done pulse.
- A subsequent load streams correctly from index 0.
REQ-040 Back-to-back: i_load asserted on the first IDLE cycle after the DONE pulse streams the new array with latency per REQ-019.
